// File: rtl/axis_tx_arb_pkg.sv
// Shared types and defaults for the two-source frame arbiter in front of pcs_top.
// Holds the arbitration state encoding, requester id type and the round-robin pick rule.
package axis_tx_arb_pkg;

  localparam int P_DATA_W_DEF    = 32;
  localparam int P_VLDB_W_DEF    = 2;
  localparam int P_RSP_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

  // A tie goes to whoever did not win last; otherwise the lone requester wins.
  function automatic req_id_t rr_pick(logic v0, logic v1, req_id_t rr_last);
    return (v0 && v1) ? ~rr_last : v1;
  endfunction

endpackage

// File: rtl/rsp_id_fifo.sv
// Small synchronous FIFO of requester ids, one entry per frame awaiting its response.
// Simultaneous push and pop are both honoured, including when full.
module rsp_id_fifo
  import axis_tx_arb_pkg::*;
#(
  parameter int  P_DEPTH = 4,
  localparam int AW      = $clog2(P_DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  req_id_t       push_id,
  input  logic          pop,
  output req_id_t       head_id,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  req_id_t       mem [P_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(P_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_id = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; pointers and count alone define valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/axis_tx_arbiter.sv
// Frame-level round-robin arbiter sharing the pcs_top AXIS tx port between two sources,
// routing each per-frame response back to the source that sent the frame.
module axis_tx_arbiter
  import axis_tx_arb_pkg::*;
#(
  parameter int  P_DATA_W    = P_DATA_W_DEF,
  parameter int  P_VLDB_W    = P_VLDB_W_DEF,
  parameter int  P_RSP_DEPTH = P_RSP_DEPTH_DEF,
  localparam int CW          = $clog2(P_RSP_DEPTH) + 1
) (
  input  logic                tx_user_clk_i,
  input  logic                tx_user_rst_i,
  input  logic [P_DATA_W-1:0] s0_tx_data_i,
  input  logic [P_VLDB_W-1:0] s0_tx_vldb_i,
  input  logic                s0_tx_valid_i,
  input  logic                s0_tx_last_i,
  input  logic                s0_tx_user_i,
  output logic                s0_tx_ready_o,
  output logic                s0_tx_status_o,
  output logic                s0_tx_rsp_valid_o,
  input  logic [P_DATA_W-1:0] s1_tx_data_i,
  input  logic [P_VLDB_W-1:0] s1_tx_vldb_i,
  input  logic                s1_tx_valid_i,
  input  logic                s1_tx_last_i,
  input  logic                s1_tx_user_i,
  output logic                s1_tx_ready_o,
  output logic                s1_tx_status_o,
  output logic                s1_tx_rsp_valid_o,
  output logic [P_DATA_W-1:0] m_tx_data_o,
  output logic [P_VLDB_W-1:0] m_tx_vldb_o,
  output logic                m_tx_valid_o,
  output logic                m_tx_last_o,
  output logic                m_tx_user_o,
  input  logic                m_tx_ready_i,
  input  logic                m_tx_status_i,
  input  logic                m_tx_rsp_valid_i,
  output logic [CW-1:0]       rsp_pending_o,
  output logic                rsp_orphan_o
);

  arb_state_t state;
  req_id_t    gnt_id;
  req_id_t    rr_last;
  req_id_t    pick;
  req_id_t    head_id;
  logic       fifo_full;
  logic       fifo_empty;
  logic       grant;
  logic       rsp_pop;
  logic       frame_done;

  // Full comes from the registered count, so a same-cycle response does not unblock a grant.
  assign pick       = rr_pick(s0_tx_valid_i, s1_tx_valid_i, rr_last);
  assign grant      = (state == IDLE) && !fifo_full && (s0_tx_valid_i || s1_tx_valid_i);
  assign rsp_pop    = m_tx_rsp_valid_i && !fifo_empty;
  assign frame_done = m_tx_valid_o && m_tx_ready_i && m_tx_last_o;

  always_ff @(posedge tx_user_clk_i) begin
    if (tx_user_rst_i) begin
      state        <= IDLE;
      gnt_id       <= 1'b0;
      rr_last      <= 1'b1;
      rsp_orphan_o <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (grant) begin
          state   <= BUSY;
          gnt_id  <= pick;
          rr_last <= pick;
        end
      end else if (frame_done) begin
        state <= IDLE;
      end
      if (m_tx_rsp_valid_i && fifo_empty) rsp_orphan_o <= 1'b1;
    end
  end

  // NOTE: every output gets a default before any branch so no path can infer a latch.
  always_comb begin
    m_tx_data_o   = '0;
    m_tx_vldb_o   = '0;
    m_tx_valid_o  = 1'b0;
    m_tx_last_o   = 1'b0;
    m_tx_user_o   = 1'b0;
    s0_tx_ready_o = 1'b0;
    s1_tx_ready_o = 1'b0;
    if (state == BUSY) begin
      if (gnt_id) begin
        m_tx_data_o   = s1_tx_data_i;
        m_tx_vldb_o   = s1_tx_vldb_i;
        m_tx_valid_o  = s1_tx_valid_i;
        m_tx_last_o   = s1_tx_last_i;
        m_tx_user_o   = s1_tx_user_i;
        s1_tx_ready_o = m_tx_ready_i;
      end else begin
        m_tx_data_o   = s0_tx_data_i;
        m_tx_vldb_o   = s0_tx_vldb_i;
        m_tx_valid_o  = s0_tx_valid_i;
        m_tx_last_o   = s0_tx_last_i;
        m_tx_user_o   = s0_tx_user_i;
        s0_tx_ready_o = m_tx_ready_i;
      end
    end
  end

  assign s0_tx_rsp_valid_o = rsp_pop && !head_id;
  assign s1_tx_rsp_valid_o = rsp_pop && head_id;
  assign s0_tx_status_o    = s0_tx_rsp_valid_o && m_tx_status_i;
  assign s1_tx_status_o    = s1_tx_rsp_valid_o && m_tx_status_i;

  rsp_id_fifo #(
    .P_DEPTH (P_RSP_DEPTH)
  ) u_rsp_id_fifo (
    .clk     (tx_user_clk_i),
    .rst     (tx_user_rst_i),
    .push    (grant),
    .push_id (pick),
    .pop     (rsp_pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (rsp_pending_o)
  );

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Bench for axis_tx_arbiter: directed scenarios plus a randomized run, all checked
// cycle by cycle against a queue-based reference model of the arbitration rules.
module tb_axis_tx_arbiter;

  localparam int DEPTH = 4;

  logic        tx_user_clk_i = 1'b0;
  logic        tx_user_rst_i;
  logic [31:0] s0_tx_data_i, s1_tx_data_i, m_tx_data_o;
  logic [1:0]  s0_tx_vldb_i, s1_tx_vldb_i, m_tx_vldb_o;
  logic        s0_tx_valid_i, s0_tx_last_i, s0_tx_user_i;
  logic        s1_tx_valid_i, s1_tx_last_i, s1_tx_user_i;
  logic        s0_tx_ready_o, s0_tx_status_o, s0_tx_rsp_valid_o;
  logic        s1_tx_ready_o, s1_tx_status_o, s1_tx_rsp_valid_o;
  logic        m_tx_valid_o, m_tx_last_o, m_tx_user_o;
  logic        m_tx_ready_i, m_tx_status_i, m_tx_rsp_valid_i;
  logic [2:0]  rsp_pending_o;
  logic        rsp_orphan_o;

  axis_tx_arbiter dut (
    .tx_user_clk_i     (tx_user_clk_i),
    .tx_user_rst_i     (tx_user_rst_i),
    .s0_tx_data_i      (s0_tx_data_i),
    .s0_tx_vldb_i      (s0_tx_vldb_i),
    .s0_tx_valid_i     (s0_tx_valid_i),
    .s0_tx_last_i      (s0_tx_last_i),
    .s0_tx_user_i      (s0_tx_user_i),
    .s0_tx_ready_o     (s0_tx_ready_o),
    .s0_tx_status_o    (s0_tx_status_o),
    .s0_tx_rsp_valid_o (s0_tx_rsp_valid_o),
    .s1_tx_data_i      (s1_tx_data_i),
    .s1_tx_vldb_i      (s1_tx_vldb_i),
    .s1_tx_valid_i     (s1_tx_valid_i),
    .s1_tx_last_i      (s1_tx_last_i),
    .s1_tx_user_i      (s1_tx_user_i),
    .s1_tx_ready_o     (s1_tx_ready_o),
    .s1_tx_status_o    (s1_tx_status_o),
    .s1_tx_rsp_valid_o (s1_tx_rsp_valid_o),
    .m_tx_data_o       (m_tx_data_o),
    .m_tx_vldb_o       (m_tx_vldb_o),
    .m_tx_valid_o      (m_tx_valid_o),
    .m_tx_last_o       (m_tx_last_o),
    .m_tx_user_o       (m_tx_user_o),
    .m_tx_ready_i      (m_tx_ready_i),
    .m_tx_status_i     (m_tx_status_i),
    .m_tx_rsp_valid_i  (m_tx_rsp_valid_i),
    .rsp_pending_o     (rsp_pending_o),
    .rsp_orphan_o      (rsp_orphan_o)
  );

  always #5 tx_user_clk_i = ~tx_user_clk_i;

  int tests = 0;
  int fails = 0;

  // Source generators: each source sends frames whose beats encode {source, frame, beat}.
  int len [2];
  int beat [2];
  int fcnt [2];
  int frames_left [2];
  int flen [2];
  bit bubble;
  int rdy_mode;
  bit rdy_tog;

  // Reference model: transaction-level view of who owns the port and which responses are owed.
  bit mdl_busy;
  int mdl_owner;
  int mdl_last;
  int mdl_q[$];
  bit mdl_orphan;

  // Observations taken from the DUT for directed checks.
  int         grant_log[$];
  int         beats_seen [2];
  int         cyc;
  int         last_cyc;
  int         min_gap;
  bit         s1_rdy_seen;
  logic       obs_mv;
  logic [31:0] obs_md;
  logic [3:0] obs_rsp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sdata(int i);
    return {8'(i), 8'(fcnt[i]), 16'(beat[i])};
  endfunction
  function automatic logic slast(int i);
    return (len[i] > 0) && (beat[i] == len[i] - 1);
  endfunction
  function automatic logic [1:0] svldb(int i);
    return 2'(beat[i]);
  endfunction
  function automatic logic suser(int i);
    return 1'(beat[i] + i);
  endfunction

  task automatic cycle();
    logic [1:0]  sv;
    logic [36:0] exp_m;
    logic [1:0]  exp_rdy;
    logic [3:0]  exp_rsp;
    bit          hs, can_grant;
    int          o, pick;
    for (int i = 0; i < 2; i++) begin
      if (len[i] == 0 && frames_left[i] > 0) begin
        len[i]  = (flen[i] == 0) ? int'($urandom_range(1, 4)) : flen[i];
        beat[i] = 0;
        frames_left[i]--;
      end
      sv[i] = (len[i] > 0) && !(bubble && ($urandom_range(0, 3) == 0));
    end
    s0_tx_valid_i = sv[0]; s0_tx_data_i = sdata(0); s0_tx_last_i = slast(0);
    s0_tx_vldb_i  = svldb(0); s0_tx_user_i = suser(0);
    s1_tx_valid_i = sv[1]; s1_tx_data_i = sdata(1); s1_tx_last_i = slast(1);
    s1_tx_vldb_i  = svldb(1); s1_tx_user_i = suser(1);
    rdy_tog = ~rdy_tog;
    case (rdy_mode)
      1:       m_tx_ready_i = rdy_tog;
      2:       m_tx_ready_i = 1'($urandom_range(0, 1));
      default: m_tx_ready_i = 1'b1;
    endcase

    @(negedge tx_user_clk_i);
    o       = mdl_owner;
    exp_m   = '0;
    exp_rdy = '0;
    exp_rsp = '0;
    if (mdl_busy) begin
      exp_m      = {sv[o], slast(o), suser(o), svldb(o), sdata(o)};
      exp_rdy[o] = m_tx_ready_i;
    end
    if (m_tx_rsp_valid_i && mdl_q.size() > 0) begin
      exp_rsp[2 + mdl_q[0]] = 1'b1;
      exp_rsp[mdl_q[0]]     = m_tx_status_i;
    end
    obs_mv  = m_tx_valid_o;
    obs_md  = m_tx_data_o;
    obs_rsp = {s1_tx_rsp_valid_o, s0_tx_rsp_valid_o, s1_tx_status_o, s0_tx_status_o};
    check("m_tx", 64'({m_tx_valid_o, m_tx_last_o, m_tx_user_o, m_tx_vldb_o, m_tx_data_o}), 64'(exp_m));
    check("ready", 64'({s1_tx_ready_o, s0_tx_ready_o}), 64'(exp_rdy));
    check("rsp", 64'(obs_rsp), 64'(exp_rsp));
    check("pending", 64'(rsp_pending_o), 64'(mdl_q.size()));
    check("orphan", 64'(rsp_orphan_o), 64'(mdl_orphan));

    s1_rdy_seen |= s1_tx_ready_o;
    if (m_tx_valid_o && m_tx_ready_i) begin
      beats_seen[int'(m_tx_data_o[24])]++;
      if (m_tx_data_o[15:0] == 16'h0) begin
        grant_log.push_back(int'(m_tx_data_o[31:24]));
        if (last_cyc >= 0 && cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
      end
      if (m_tx_last_o) last_cyc = cyc;
    end

    hs        = mdl_busy && sv[o] && m_tx_ready_i;
    can_grant = !mdl_busy && (mdl_q.size() < DEPTH) && (sv != 2'b00);
    pick      = (sv == 2'b11) ? ((mdl_last == 0) ? 1 : 0) : (sv[1] ? 1 : 0);
    if (m_tx_rsp_valid_i) begin
      if (mdl_q.size() > 0) void'(mdl_q.pop_front());
      else mdl_orphan = 1'b1;
    end
    if (can_grant) begin
      mdl_busy  = 1'b1;
      mdl_owner = pick;
      mdl_last  = pick;
      mdl_q.push_back(pick);
    end else if (hs && slast(o)) begin
      mdl_busy = 1'b0;
    end
    if (hs) begin
      if (slast(o)) begin
        len[o] = 0;
        fcnt[o]++;
      end else begin
        beat[o]++;
      end
    end

    @(posedge tx_user_clk_i);
    #1;
    cyc++;
    m_tx_rsp_valid_i = 1'b0;
    m_tx_status_i    = 1'b0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      len[i] = 0; beat[i] = 0; fcnt[i] = 0; frames_left[i] = 0; flen[i] = 1;
      beats_seen[i] = 0;
    end
    bubble = 1'b0; rdy_mode = 0; rdy_tog = 1'b0;
    s0_tx_valid_i = 1'b0; s0_tx_data_i = '0; s0_tx_last_i = 1'b0; s0_tx_vldb_i = '0; s0_tx_user_i = 1'b0;
    s1_tx_valid_i = 1'b0; s1_tx_data_i = '0; s1_tx_last_i = 1'b0; s1_tx_vldb_i = '0; s1_tx_user_i = 1'b0;
    m_tx_ready_i = 1'b0; m_tx_rsp_valid_i = 1'b0; m_tx_status_i = 1'b0;
    tx_user_rst_i = 1'b1;
    repeat (2) @(posedge tx_user_clk_i);
    #1;
    tx_user_rst_i = 1'b0;
    mdl_busy = 1'b0; mdl_owner = 0; mdl_last = 1; mdl_q.delete(); mdl_orphan = 1'b0;
    grant_log.delete(); last_cyc = -1; min_gap = 1000; s1_rdy_seen = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mvalid"}, 64'(m_tx_valid_o), 64'd0);
    check({tag, "_ready"}, 64'({s1_tx_ready_o, s0_tx_ready_o}), 64'd0);
    check({tag, "_pending"}, 64'(rsp_pending_o), 64'd0);
    check({tag, "_orphan"}, 64'(rsp_orphan_o), 64'd0);
  endtask

  initial begin
    int exp_g [4];
    cyc = 0;

    // Reset state
    do_reset();
    check_reset_state("reset");

    // Lone s0 sends a 3-beat frame; first beat one cycle after valid
    frames_left[0] = 1; flen[0] = 3;
    cycle();
    check("t1_idle_first", 64'(obs_mv), 64'd0);
    cycle();
    check("t1_beat0_valid", 64'(obs_mv), 64'd1);
    check("t1_beat0_data", 64'(obs_md), 64'h0000_0000);
    repeat (4) cycle();
    check("t1_beats", 64'(beats_seen[0]), 64'd3);
    check("t1_s1_ready", 64'(s1_rdy_seen), 64'd0);
    check("t1_pending", 64'(rsp_pending_o), 64'd1);

    // Both sources continuously: grants alternate starting at 0, one idle cycle between frames
    do_reset();
    frames_left = '{2, 2}; flen = '{2, 2};
    repeat (16) cycle();
    exp_g = '{0, 1, 0, 1};
    check("t2_ngrants", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      check("t2_grant_order", 64'(grant_log[i]), 64'(exp_g[i]));
    check("t2_min_gap", 64'(min_gap), 64'd2);
    check("t2_pending", 64'(rsp_pending_o), 64'd4);

    // s1 4-beat frame under toggling downstream ready
    do_reset();
    frames_left[1] = 1; flen[1] = 4; rdy_mode = 1;
    repeat (14) cycle();
    check("t3_beats", 64'(beats_seen[1]), 64'd4);
    check("t3_ngrants", 64'(grant_log.size()), 64'd1);

    // s0, s1, s0 frames then three responses routed back in order
    do_reset();
    frames_left = '{2, 1}; flen = '{1, 1};
    repeat (8) cycle();
    exp_g = '{0, 1, 0, 0};
    check("t4_ngrants", 64'(grant_log.size()), 64'd3);
    for (int i = 0; i < grant_log.size() && i < 3; i++)
      check("t4_grant_order", 64'(grant_log[i]), 64'(exp_g[i]));
    check("t4_pending3", 64'(rsp_pending_o), 64'd3);
    m_tx_rsp_valid_i = 1'b1; m_tx_status_i = 1'b1;
    cycle();
    check("t4_rsp_a", 64'(obs_rsp), 64'b0101);
    m_tx_rsp_valid_i = 1'b1; m_tx_status_i = 1'b0;
    cycle();
    check("t4_rsp_b", 64'(obs_rsp), 64'b1000);
    m_tx_rsp_valid_i = 1'b1; m_tx_status_i = 1'b1;
    cycle();
    check("t4_rsp_c", 64'(obs_rsp), 64'b0101);
    check("t4_pending0", 64'(rsp_pending_o), 64'd0);

    // FIFO full blocks the 5th grant until a response frees a slot
    do_reset();
    frames_left[0] = 5; flen[0] = 1;
    repeat (12) cycle();
    check("t5_pending_full", 64'(rsp_pending_o), 64'd4);
    check("t5_beats_blocked", 64'(beats_seen[0]), 64'd4);
    m_tx_rsp_valid_i = 1'b1;
    cycle();
    check("t5_rsp_cycle_mvalid", 64'(obs_mv), 64'd0);
    check("t5_rsp_cycle_rsp", 64'(obs_rsp), 64'b0100);
    cycle();
    check("t5_grant_cycle_mvalid", 64'(obs_mv), 64'd0);
    cycle();
    check("t5_beat_mvalid", 64'(obs_mv), 64'd1);
    check("t5_pending_refill", 64'(rsp_pending_o), 64'd4);
    check("t5_beats_done", 64'(beats_seen[0]), 64'd5);

    // Orphan response: no routed strobe, sticky flag until reset
    do_reset();
    m_tx_rsp_valid_i = 1'b1; m_tx_status_i = 1'b1;
    cycle();
    check("t6_no_route", 64'(obs_rsp), 64'd0);
    check("t6_orphan_set", 64'(rsp_orphan_o), 64'd1);
    repeat (3) cycle();
    check("t6_orphan_sticky", 64'(rsp_orphan_o), 64'd1);
    do_reset();
    check("t6_orphan_cleared", 64'(rsp_orphan_o), 64'd0);

    // Randomized traffic, bubbles, ready and responses, with a reset dropped mid-run
    do_reset();
    frames_left = '{1000, 1000}; flen = '{0, 0}; bubble = 1'b1; rdy_mode = 2;
    for (int n = 0; n < 1400; n++) begin
      if (n == 700) begin
        do_reset();
        check_reset_state("midrun_reset");
        frames_left = '{1000, 1000}; flen = '{0, 0}; bubble = 1'b1; rdy_mode = 2;
      end
      m_tx_rsp_valid_i = ($urandom_range(0, 3) == 0);
      m_tx_status_i    = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
